// File: rtl/ttt_pkg.sv
// TTT sequencer shared types: processor opcodes, FSM states,
// and the host-command legality check.
package ttt_pkg;

  typedef enum logic [3:0] {
    OP_ADD_GOOD  = 4'h0,
    OP_ADD_BAD   = 4'h1,
    OP_REG_2     = 4'h2,
    OP_REG_3     = 4'h3,
    OP_REG_4     = 4'h4,
    OP_REG_5     = 4'h5,
    OP_REG_6     = 4'h6,
    OP_REG_7     = 4'h7,
    OP_TALLY     = 4'h8,
    OP_COUNTDOWN = 4'h9,
    OP_SET_GTHR  = 4'hA,
    OP_GET_GTHR  = 4'hB,
    OP_SET_BTHR  = 4'hC,
    OP_GET_BTHR  = 4'hD,
    OP_SET_DUR   = 4'hE,
    OP_GET_DUR   = 4'hF
  } instr_e;

  typedef enum logic [3:0] {
    IDLE,
    S_GOOD,
    S_BAD,
    S_TALLY,
    S_SMP_T,
    S_COUNT,
    S_SMP_C,
    C_ISSUE,
    C_CAPT,
    C_RSP
  } seq_state_e;

  // Step micro-ops are reserved for the step FSM.
  function automatic logic is_legal_cmd(input logic [3:0] op);
    logic ok;
    ok = 1'b1;
    unique case (1'b1)
      op == OP_ADD_GOOD:  ok = 1'b0;
      op == OP_ADD_BAD:   ok = 1'b0;
      op == OP_TALLY:     ok = 1'b0;
      op == OP_COUNTDOWN: ok = 1'b0;
      default:            ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ttt_reset_stretch.sv
// Processor reset generator: asserts with reset_n, releases
// CYCLES clocks after reset_n rises.
module ttt_reset_stretch #(
  parameter int CYCLES = 2
) (
  input  logic clock,
  input  logic reset_n,
  output logic proc_reset
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      proc_reset <= 1'b1;
    end else if (proc_reset) begin
      cnt <= cnt + 1'b1;
      if (cnt == CW'(CYCLES - 1))
        proc_reset <= 1'b0;
    end
  end

endmodule

// File: rtl/ttt_sequencer.sv
// TTT processor control initiator: per-step micro-op sequences,
// host register commands and condensed start/stop events.
import ttt_pkg::*;

module ttt_sequencer #(
  parameter int NEW_TOKEN_BITS    = 4,
  parameter int DATA_BITS         = 8,
  parameter int INSTRUCTION_BITS  = 4,
  parameter int PROC_RESET_CYCLES = 2,
  parameter int STEP_COUNT_BITS   = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        step_valid,
  output logic                        step_ready,
  input  logic [NEW_TOKEN_BITS-1:0]   step_good,
  input  logic [NEW_TOKEN_BITS-1:0]   step_bad,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [INSTRUCTION_BITS-1:0] cmd_op,
  input  logic [DATA_BITS-1:0]        cmd_data,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_BITS-1:0]        rsp_data,
  output logic                        rsp_err,
  output logic                        evt_start,
  output logic                        evt_stop,
  output logic                        step_done,
  output logic [STEP_COUNT_BITS-1:0]  step_count,
  output logic                        proc_reset,
  output logic                        proc_enable,
  output logic [INSTRUCTION_BITS-1:0] proc_instruction,
  output logic [NEW_TOKEN_BITS-1:0]   proc_good_tokens,
  output logic [NEW_TOKEN_BITS-1:0]   proc_bad_tokens,
  output logic [DATA_BITS-1:0]        proc_data_in,
  input  logic [DATA_BITS-1:0]        proc_data_out,
  input  logic                        proc_token_start,
  input  logic                        proc_token_stop
);

  localparam int IB = INSTRUCTION_BITS;

  seq_state_e state;
  logic       start_t;
  logic       stop_t;
  logic       step_go;
  logic       cmd_go;

  ttt_reset_stretch #(
    .CYCLES(PROC_RESET_CYCLES)
  ) u_rst (
    .clock     (clock),
    .reset_n   (reset_n),
    .proc_reset(proc_reset)
  );

  assign step_ready = (state == IDLE) && !proc_reset;
  assign cmd_ready  = step_ready && !step_valid;
  assign step_go    = step_valid && step_ready;
  assign cmd_go     = cmd_valid && cmd_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      start_t          <= 1'b0;
      stop_t           <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_data         <= '0;
      rsp_err          <= 1'b0;
      evt_start        <= 1'b0;
      evt_stop         <= 1'b0;
      step_done        <= 1'b0;
      step_count       <= '0;
      proc_enable      <= 1'b0;
      proc_instruction <= '0;
      proc_good_tokens <= '0;
      proc_bad_tokens  <= '0;
      proc_data_in     <= '0;
    end else begin
      proc_enable      <= 1'b0;
      proc_instruction <= '0;
      step_done        <= 1'b0;
      evt_start        <= 1'b0;
      evt_stop         <= 1'b0;
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            step_go: begin
              proc_good_tokens <= step_good;
              proc_bad_tokens  <= step_bad;
              proc_enable      <= 1'b1;
              proc_instruction <= IB'(OP_ADD_GOOD);
              state            <= S_GOOD;
            end
            cmd_go: begin
              proc_data_in <= cmd_data;
              if (is_legal_cmd(4'(cmd_op))) begin
                proc_enable      <= 1'b1;
                proc_instruction <= cmd_op;
                state            <= C_ISSUE;
              end else begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                rsp_data  <= '0;
                state     <= C_RSP;
              end
            end
            default: ;
          endcase
        end
        S_GOOD: begin
          proc_enable      <= 1'b1;
          proc_instruction <= IB'(OP_ADD_BAD);
          state            <= S_BAD;
        end
        S_BAD: begin
          proc_enable      <= 1'b1;
          proc_instruction <= IB'(OP_TALLY);
          state            <= S_TALLY;
        end
        S_TALLY: state <= S_SMP_T;
        S_SMP_T: begin
          start_t          <= proc_token_start;
          stop_t           <= proc_token_stop;
          proc_enable      <= 1'b1;
          proc_instruction <= IB'(OP_COUNTDOWN);
          state            <= S_COUNT;
        end
        S_COUNT: state <= S_SMP_C;
        S_SMP_C: begin
          // A stop flag still held from TALLY must not count twice.
          evt_start  <= start_t;
          evt_stop   <= stop_t | (proc_token_stop & ~stop_t);
          step_done  <= 1'b1;
          step_count <= step_count + 1'b1;
          state      <= IDLE;
        end
        C_ISSUE: state <= C_CAPT;
        C_CAPT: begin
          rsp_data  <= proc_data_out;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= C_RSP;
        end
        C_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ttt_sequencer.sv
// Scoreboard bench for ttt_sequencer paired with a small
// behavioural TTT processor model.
module tb_ttt_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        step_valid, step_ready;
  logic [3:0]  step_good, step_bad;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [7:0]  rsp_data;
  logic        evt_start, evt_stop, step_done;
  logic [15:0] step_count;
  logic        proc_reset, proc_enable;
  logic [3:0]  proc_instruction, proc_good_tokens, proc_bad_tokens;
  logic [7:0]  proc_data_in, proc_data_out;
  logic        proc_token_start, proc_token_stop;

  always #5 clock = ~clock;

  ttt_sequencer dut (
    .clock(clock), .reset_n(reset_n),
    .step_valid(step_valid), .step_ready(step_ready),
    .step_good(step_good), .step_bad(step_bad),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .evt_start(evt_start), .evt_stop(evt_stop),
    .step_done(step_done), .step_count(step_count),
    .proc_reset(proc_reset), .proc_enable(proc_enable),
    .proc_instruction(proc_instruction),
    .proc_good_tokens(proc_good_tokens),
    .proc_bad_tokens(proc_bad_tokens),
    .proc_data_in(proc_data_in),
    .proc_data_out(proc_data_out),
    .proc_token_start(proc_token_start),
    .proc_token_stop(proc_token_stop)
  );

  // Processor model: accumulators, thresholds, countdown timer.
  int         gacc, bacc, timer;
  logic       active;
  logic [7:0] gthr, bthr, dur;

  always_ff @(posedge clock or posedge proc_reset) begin
    if (proc_reset) begin
      gacc <= 0; bacc <= 0; timer <= 0; active <= 1'b0;
      gthr <= '0; bthr <= '0; dur <= '0;
      proc_data_out <= '0;
      proc_token_start <= 1'b0;
      proc_token_stop <= 1'b0;
    end else if (proc_enable) begin
      proc_token_start <= 1'b0;
      proc_token_stop <= 1'b0;
      case (proc_instruction)
        4'h0: gacc <= gacc + int'($signed(proc_good_tokens));
        4'h1: bacc <= bacc + int'($signed(proc_bad_tokens));
        4'h8: begin
          bacc <= 0;
          if (!active && gacc >= int'(gthr)) begin
            active <= 1'b1; timer <= int'(dur);
            proc_token_start <= 1'b1; gacc <= 0;
          end else if (active && bacc >= int'(bthr)) begin
            active <= 1'b0; proc_token_stop <= 1'b1;
          end
        end
        4'h9: if (active) begin
          if (timer <= 1) begin
            active <= 1'b0; timer <= 0; proc_token_stop <= 1'b1;
          end else timer <= timer - 1;
        end
        4'hA: begin gthr <= proc_data_in; proc_data_out <= proc_data_in; end
        4'hB: proc_data_out <= gthr;
        4'hC: begin bthr <= proc_data_in; proc_data_out <= proc_data_in; end
        4'hD: proc_data_out <= bthr;
        4'hE: begin dur <= proc_data_in; proc_data_out <= proc_data_in; end
        4'hF: proc_data_out <= dur;
        default: proc_data_out <= '0;
      endcase
    end
  end

  int total = 0;
  int passed = 0;

  logic [3:0]  op_q[$];
  logic [8:0]  rsp_q[$];
  logic [17:0] evt_q[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    total++;
    $display("FAIL %s", name);
  endtask

  // Monitor: pops expectations whenever the DUT presents output.
  always @(negedge clock) begin
    if (reset_n) begin
      if (proc_enable) begin
        if (op_q.size() == 0) fail("op_unexpected");
        else chk("op", proc_instruction, op_q.pop_front());
      end else if (proc_instruction != 4'h0) begin
        fail("instr_nonzero_idle");
      end
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) fail("rsp_unexpected");
        else chk("rsp", {rsp_err, rsp_data}, rsp_q.pop_front());
      end
      if (step_done) begin
        if (evt_q.size() == 0) fail("evt_unexpected");
        else chk("evt", {evt_start, evt_stop, step_count},
                 evt_q.pop_front());
      end else if (evt_start || evt_stop) begin
        fail("evt_stray");
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic start_step(input logic [3:0] g, input logic [3:0] b);
    bit ok;
    ok = 1'b0;
    step_good = g; step_bad = b; step_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (step_ready) begin ok = 1'b1; break; end
    end
    if (!ok) fail("step_hs_timeout");
    tick;
    step_valid = 1'b0;
    chk("good_latch", proc_good_tokens, g);
    chk("bad_latch", proc_bad_tokens, b);
  endtask

  task automatic run_step(input logic [3:0] g, input logic [3:0] b,
                          input logic es, input logic et,
                          input logic [15:0] cnt);
    int lat;
    logic [5:0] pat;
    lat = 0; pat = '0;
    op_q.push_back(4'h0); op_q.push_back(4'h1);
    op_q.push_back(4'h8); op_q.push_back(4'h9);
    evt_q.push_back({es, et, cnt});
    start_step(g, b);
    for (int i = 1; i <= 12; i++) begin
      if (i <= 6) pat = {pat[4:0], proc_enable};
      tick;
      if (step_done) begin lat = i; break; end
    end
    if (lat == 0) fail("step_done_timeout");
    else chk("step_lat", lat, 6);
    chk("en_pattern", pat, 6'b111010);
  endtask

  task automatic wait_rsp;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (rsp_valid && rsp_ready) begin ok = 1'b1; break; end
    end
    if (!ok) fail("rsp_timeout");
    tick;
  endtask

  task automatic issue_cmd(input logic [3:0] op, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) fail("cmd_hs_timeout");
    tick;
    cmd_valid = 1'b0;
    chk("data_in_latch", proc_data_in, d);
  endtask

  task automatic do_cmd(input logic [3:0] op, input logic [7:0] d,
                        input logic [7:0] ed, input logic ee);
    if (!(op inside {4'h0, 4'h1, 4'h8, 4'h9})) op_q.push_back(op);
    rsp_q.push_back({ee, ed});
    issue_cmd(op, d);
    wait_rsp;
  endtask

  initial begin : main
    bit ok;
    step_valid = 0; step_good = 0; step_bad = 0;
    cmd_valid = 0; cmd_op = 0; cmd_data = 0; rsp_ready = 1;
    repeat (3) tick;

    chk("rst_proc_reset", proc_reset, 1);
    chk("rst_outs", {proc_enable, proc_instruction, step_done,
        evt_start, evt_stop, rsp_valid, rsp_err, step_ready,
        cmd_ready, step_count}, 0);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    chk("prst_hold", proc_reset, 1);
    chk("prst_no_accept", step_ready, 0);
    @(posedge clock); #1;
    chk("prst_fall", proc_reset, 0);

    // Step aborted by reset while in S_TALLY.
    op_q.push_back(4'h0); op_q.push_back(4'h1); op_q.push_back(4'h8);
    start_step(4'h3, 4'h2);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (proc_enable && proc_instruction == 4'h8) begin
        ok = 1'b1; break;
      end
    end
    if (!ok) fail("tally_timeout");
    #1 reset_n = 1'b0;
    #1;
    chk("abort_proc_reset", proc_reset, 1);
    chk("abort_outs", {proc_enable, proc_instruction, step_done,
        evt_start, evt_stop, rsp_valid, rsp_err, step_ready,
        cmd_ready, step_count}, 0);
    chk("abort_latches", {proc_good_tokens, proc_bad_tokens,
        proc_data_in, rsp_data}, 0);
    repeat (2) @(posedge clock);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    chk("prst2_hold", proc_reset, 1);
    @(posedge clock); #1;
    chk("prst2_fall", proc_reset, 0);
    chk("idle_after_rst", step_ready, 1);

    // Program thresholds and read them back.
    do_cmd(4'hA, 8'd2, 8'd2, 1'b0);
    do_cmd(4'hC, 8'd1, 8'd1, 1'b0);
    do_cmd(4'hE, 8'd3, 8'd3, 1'b0);
    do_cmd(4'hB, 8'd0, 8'd2, 1'b0);
    do_cmd(4'hD, 8'd0, 8'd1, 1'b0);
    do_cmd(4'hF, 8'd0, 8'd3, 1'b0);

    // Token start, countdown to stop, then a quiet step.
    run_step(4'd2, 4'd0, 1'b1, 1'b0, 16'd1);
    run_step(4'd0, 4'd0, 1'b0, 1'b0, 16'd2);
    run_step(4'd0, 4'd0, 1'b0, 1'b1, 16'd3);
    run_step(4'd0, 4'd0, 1'b0, 1'b0, 16'd4);

    // Same-cycle step and command: step wins.
    op_q.push_back(4'h0); op_q.push_back(4'h1);
    op_q.push_back(4'h8); op_q.push_back(4'h9);
    op_q.push_back(4'hB);
    evt_q.push_back({1'b0, 1'b0, 16'd5});
    rsp_q.push_back({1'b0, 8'd2});
    step_good = 4'hF; step_bad = 4'h1; step_valid = 1'b1;
    cmd_op = 4'hB; cmd_data = 8'h55; cmd_valid = 1'b1;
    @(negedge clock);
    chk("arb_step_ready", step_ready, 1);
    chk("arb_cmd_ready", cmd_ready, 0);
    tick;
    step_valid = 1'b0;
    chk("neg_good_latch", proc_good_tokens, 4'hF);
    chk("arb_bad_latch", proc_bad_tokens, 4'h1);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (cmd_ready) begin
        ok = 1'b1;
        chk("cmd_wait", i, 6);
        chk("cmd_at_done", step_done, 1);
        break;
      end
    end
    if (!ok) fail("arb_cmd_timeout");
    tick;
    cmd_valid = 1'b0;
    chk("arb_data_in", proc_data_in, 8'h55);
    wait_rsp;

    // Illegal command with a stalled response.
    rsp_ready = 1'b0;
    rsp_q.push_back({1'b1, 8'd0});
    issue_cmd(4'h8, 8'hAA);
    step_valid = 1'b1; step_good = 4'd1; step_bad = 4'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("rsp_hold", rsp_valid, 1);
      chk("rsp_busy_step", step_ready, 0);
    end
    chk("illegal_rsp", {rsp_err, rsp_data}, {1'b1, 8'd0});
    tick;
    step_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_rsp;
    chk("rsp_cleared", rsp_valid, 0);
    chk("back_idle", step_ready, 1);

    repeat (3) tick;
    chk("op_q_empty", op_q.size(), 0);
    chk("rsp_q_empty", rsp_q.size(), 0);
    chk("evt_q_empty", evt_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
